// File: rtl/row_display_arbiter.sv
// 8x8 playfield row store with clear/write/scan arbitration on one port
// and a blanked, one-row-at-a-time LED matrix scanner.
module row_display_arbiter #(
  parameter int ROWS  = 8,
  parameter int WIDTH = 8,
  parameter int DWELL = 1024,
  parameter int BLANK = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clr_req,
  input  logic             wr_strobe,
  input  logic [2:0]       wr_row,
  input  logic [WIDTH-1:0] wr_val,
  output logic             wr_ack,
  output logic             wr_overrun,
  output logic             clr_busy,
  output logic [ROWS-1:0]  row_sel,
  output logic [WIDTH-1:0] cols,
  output logic             frame_tick
);

  localparam int CMAX = (DWELL > BLANK) ? DWELL : BLANK;
  localparam int CW   = $clog2(CMAX) + 1;

  typedef enum logic {
    A_IDLE,
    A_CLEAR
  } arb_t;

  typedef enum logic [1:0] {
    S_BLANK,
    S_FETCH,
    S_SHOW
  } scan_t;

  logic [WIDTH-1:0] mem [ROWS];

  arb_t             arb_q, arb_d;
  logic [2:0]       clr_idx_q;
  logic             clr_q;
  logic             clr_rise;
  logic             sweep_start;
  logic             commit;

  logic             pend_v;
  logic [2:0]       pend_row;
  logic [WIDTH-1:0] pend_val;

  scan_t            sc_q, sc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [2:0]       row_q, row_d;
  logic             fetch_ok;
  logic             last_show;

  always_comb begin
    clr_rise    = clr_req & ~clr_q;
    sweep_start = clr_rise && (arb_q == A_IDLE);
    commit      = pend_v && (arb_q == A_IDLE) && !sweep_start;
    arb_d       = arb_q;
    if (arb_q == A_IDLE) begin
      if (sweep_start) arb_d = A_CLEAR;
    end else begin
      if (clr_idx_q == 3'(ROWS-1)) arb_d = A_IDLE;
    end
  end

  // Scan read only when neither a sweep nor a commit wants the port.
  assign fetch_ok = (sc_q == S_FETCH) && (arb_q == A_IDLE)
                  && !clr_rise && !pend_v;

  assign clr_busy = (arb_q == A_CLEAR);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < ROWS; i++) mem[i] <= '0;
      arb_q      <= A_IDLE;
      clr_idx_q  <= '0;
      clr_q      <= 1'b0;
      pend_v     <= 1'b0;
      pend_row   <= '0;
      pend_val   <= '0;
      wr_ack     <= 1'b0;
      wr_overrun <= 1'b0;
      cols       <= '0;
    end else begin
      clr_q      <= clr_req;
      arb_q      <= arb_d;
      wr_ack     <= commit;
      wr_overrun <= wr_strobe && pend_v && !commit && !sweep_start;

      if (arb_q == A_CLEAR) begin
        mem[clr_idx_q] <= '0;
        clr_idx_q      <= (clr_idx_q == 3'(ROWS-1)) ? 3'd0 : clr_idx_q + 3'd1;
      end else if (commit) begin
        mem[pend_row] <= pend_val;
      end

      if (sweep_start) clr_idx_q <= '0;

      // A strobe on the sweep-start cycle is newer than the clear: keep it.
      if (sweep_start) begin
        pend_v <= wr_strobe;
        if (wr_strobe) begin
          pend_row <= wr_row;
          pend_val <= wr_val;
        end
      end else if (wr_strobe) begin
        pend_v   <= 1'b1;
        pend_row <= wr_row;
        pend_val <= wr_val;
      end else if (commit) begin
        pend_v <= 1'b0;
      end

      if (fetch_ok) cols <= mem[row_q];
    end
  end

  assign last_show = (sc_q == S_SHOW) && (cnt_q == CW'(DWELL-1));

  always_comb begin
    sc_d  = sc_q;
    cnt_d = cnt_q;
    row_d = row_q;
    unique case (sc_q)
      S_BLANK: begin
        if (cnt_q == CW'(BLANK-1)) begin
          sc_d  = S_FETCH;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_FETCH: begin
        if (fetch_ok) sc_d = S_SHOW;
      end
      S_SHOW: begin
        if (last_show) begin
          sc_d  = S_BLANK;
          cnt_d = '0;
          row_d = (row_q == 3'(ROWS-1)) ? 3'd0 : row_q + 3'd1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        sc_d  = S_BLANK;
        cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sc_q  <= S_BLANK;
      cnt_q <= '0;
      row_q <= '0;
    end else begin
      sc_q  <= sc_d;
      cnt_q <= cnt_d;
      row_q <= row_d;
    end
  end

  always_comb begin
    row_sel = '0;
    if (sc_q == S_SHOW) row_sel[row_q] = 1'b1;
  end

  assign frame_tick = last_show && (row_q == 3'(ROWS-1));

endmodule

// File: tb/tb_row_display_arbiter.sv
// Directed scoreboard bench for row_display_arbiter: writes, sweeps,
// overruns, fetch stalls and mid-sweep reset.
module tb_row_display_arbiter;

  localparam int DW    = 20;
  localparam int BL    = 4;
  localparam int FRAME = 8 * (DW + BL + 1);
  localparam int LIM   = 1000;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       clr_req;
  logic       wr_strobe;
  logic [2:0] wr_row;
  logic [7:0] wr_val;
  logic       wr_ack;
  logic       wr_overrun;
  logic       clr_busy;
  logic [7:0] row_sel;
  logic [7:0] cols;
  logic       frame_tick;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int n_ack = 0;
  int n_ovr = 0;
  int n_busy = 0;

  typedef struct {
    int         row;
    logic [7:0] v;
  } exp_t;

  exp_t       exp_q [$];
  logic [7:0] model [8];

  row_display_arbiter #(
    .ROWS (8),
    .WIDTH(8),
    .DWELL(DW),
    .BLANK(BL)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .clr_req   (clr_req),
    .wr_strobe (wr_strobe),
    .wr_row    (wr_row),
    .wr_val    (wr_val),
    .wr_ack    (wr_ack),
    .wr_overrun(wr_overrun),
    .clr_busy  (clr_busy),
    .row_sel   (row_sel),
    .cols      (cols),
    .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (wr_ack === 1'b1) n_ack++;
    if (wr_overrun === 1'b1) n_ovr++;
    if (clr_busy === 1'b1) n_busy++;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [2:0] r, input logic [7:0] v);
    wr_strobe = 1'b1;
    wr_row    = r;
    wr_val    = v;
    tick(1);
    wr_strobe = 1'b0;
  endtask

  task automatic wait_tick();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (frame_tick !== 1'b1 && n < LIM);
    chk("tick_wait", 32'(n < LIM), 32'd1);
  endtask

  task automatic wait_show(input int r);
    logic [7:0] oh;
    int n = 0;
    oh = 8'h01 << r;
    while (row_sel !== oh && n < LIM) begin
      @(negedge clk);
      n++;
    end
    chk("show_wait", 32'(n < LIM), 32'd1);
  endtask

  task automatic push_frame();
    exp_t e;
    for (int i = 0; i < 8; i++) begin
      e.row = i;
      e.v   = model[i];
      exp_q.push_back(e);
    end
  endtask

  task automatic drain();
    exp_t e;
    wait_tick();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      wait_show(e.row);
      chk($sformatf("row%0d_cols", e.row), 32'(cols), 32'(e.v));
    end
  endtask

  task automatic zero_model();
    for (int i = 0; i < 8; i++) model[i] = 8'h00;
  endtask

  initial begin
    int a0;
    int o0;
    int b0;
    int t1;
    reset_n   = 1'b0;
    clr_req   = 1'b0;
    wr_strobe = 1'b0;
    wr_row    = 3'd0;
    wr_val    = 8'h00;
    zero_model();
    tick(3);
    chk("rst_row_sel", 32'(row_sel), 32'd0);
    chk("rst_cols", 32'(cols), 32'd0);
    chk("rst_ack", 32'(wr_ack), 32'd0);
    chk("rst_ovr", 32'(wr_overrun), 32'd0);
    chk("rst_busy", 32'(clr_busy), 32'd0);
    chk("rst_tick", 32'(frame_tick), 32'd0);
    reset_n = 1'b1;
    tick(1);

    // single write while idle
    wr(3'd3, 8'hE0);
    chk("ack_early", 32'(wr_ack), 32'd0);
    tick(1);
    chk("ack_lat2", 32'(wr_ack), 32'd1);
    model[3] = 8'hE0;
    push_frame();
    drain();

    // fill all rows, then clear
    a0 = n_ack;
    o0 = n_ovr;
    for (int i = 0; i < 8; i++) wr(3'(i), 8'hFF);
    tick(5);
    chk("fill_acks", 32'(n_ack - a0), 32'd8);
    chk("fill_ovr", 32'(n_ovr - o0), 32'd0);
    for (int i = 0; i < 8; i++) model[i] = 8'hFF;
    push_frame();
    drain();
    b0 = n_busy;
    clr_req = 1'b1;
    tick(1);
    chk("busy_first", 32'(clr_busy), 32'd1);
    tick(7);
    chk("busy_last", 32'(clr_busy), 32'd1);
    tick(1);
    chk("busy_end", 32'(clr_busy), 32'd0);
    tick(30);
    chk("busy_len", 32'(n_busy - b0), 32'd8);
    zero_model();
    push_frame();
    drain();
    wait_tick();
    t1 = cyc;
    wait_tick();
    chk("frame_period", 32'(cyc - t1), 32'(FRAME));

    // two strobes during a sweep
    clr_req = 1'b0;
    tick(2);
    a0 = n_ack;
    o0 = n_ovr;
    clr_req = 1'b1;
    tick(1);
    wr(3'd1, 8'h18);
    wr(3'd1, 8'h3C);
    chk("ovr_pulse", 32'(wr_overrun), 32'd1);
    tick(20);
    chk("sweep_acks", 32'(n_ack - a0), 32'd1);
    chk("sweep_ovr", 32'(n_ovr - o0), 32'd1);
    zero_model();
    model[1] = 8'h3C;
    push_frame();
    drain();

    // strobe on the clear rising-edge cycle
    clr_req = 1'b0;
    tick(2);
    a0 = n_ack;
    b0 = n_busy;
    clr_req = 1'b1;
    wr(3'd0, 8'h07);
    chk("edge_busy", 32'(clr_busy), 32'd1);
    tick(20);
    chk("edge_acks", 32'(n_ack - a0), 32'd1);
    chk("edge_busy_len", 32'(n_busy - b0), 32'd8);
    zero_model();
    model[0] = 8'h07;
    push_frame();
    drain();

    // commit pending during row-0 FETCH stalls the scanner one cycle
    wait_tick();
    tick(BL);
    a0 = n_ack;
    wr(3'd0, 8'h5A);
    tick(1);
    chk("stall_row_sel", 32'(row_sel), 32'd0);
    tick(1);
    chk("post_stall_sel", 32'(row_sel), 32'h01);
    chk("post_stall_cols", 32'(cols), 32'h5A);
    chk("stall_ack", 32'(n_ack - a0), 32'd1);

    // reset in the middle of a sweep with a write pending
    clr_req = 1'b0;
    tick(2);
    wr(3'd2, 8'hAA);
    tick(5);
    clr_req = 1'b1;
    tick(1);
    wr(3'd5, 8'h33);
    tick(2);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_sel", 32'(row_sel), 32'd0);
    chk("mid_rst_cols", 32'(cols), 32'd0);
    chk("mid_rst_ack", 32'(wr_ack), 32'd0);
    chk("mid_rst_ovr", 32'(wr_overrun), 32'd0);
    chk("mid_rst_busy", 32'(clr_busy), 32'd0);
    chk("mid_rst_tick", 32'(frame_tick), 32'd0);
    clr_req = 1'b0;
    tick(2);
    reset_n = 1'b1;
    a0 = n_ack;
    b0 = n_busy;
    tick(30);
    chk("post_rst_ack", 32'(n_ack - a0), 32'd0);
    chk("post_rst_busy", 32'(n_busy - b0), 32'd0);
    zero_model();
    push_frame();
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/row_display_arbiter.md
Name: row_display_arbiter

Overview:
- Owns the 8x8 playfield row store and arbitrates single-port access among three requesters: clear sweep, game-FSM row writes, and the LED-matrix scan fetch.
- Sits between the game FSM (clrarray, writeStrobe, rowIndex, val) and the multiplexed matrix driver pins.
- Drives one row at a time with blanking between rows.

Parameters:
ROWS, 8, number of stored/scanned rows (rows index width 3)
WIDTH, 8, bits per row
DWELL, 1024, clk cycles each row is lit
BLANK, 16, clk cycles all rows off between rows (anti-ghosting)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous, active-low reset
clr_req  in  1  clear request, level (from game FSM clrarray)
wr_strobe  in  1  row write request, single-cycle pulse
wr_row  in  3  row index for write
wr_val  in  WIDTH  row data for write
wr_ack  out  1  1-cycle pulse when a write commits to the store
wr_overrun  out  1  1-cycle pulse when a pending write is overwritten
clr_busy  out  1  high while clear sweep runs
row_sel  out  ROWS  one-hot row enable to matrix, all-zero when blanked
cols  out  WIDTH  column data for lit row
frame_tick  out  1  1-cycle pulse at end of last row's dwell

Behaviour:
- Reset (async assert, sync release): store all zero; row_sel=0, cols=0; wr_ack, wr_overrun, clr_busy, frame_tick=0; pending write empty; scanner in BLANK, row 0, counter 0; arbiter IDLE.
- Store is single-port: exactly one access (clear write, pending-write commit, or scan read) per cycle. Priority: clear > write commit > scan fetch.
- Clear:
  - Rising edge of clr_req (registered previous value) starts a sweep: CLEAR state zeroes rows 0..ROWS-1, one per cycle (8 cycles).
  - clr_busy is high from the cycle after the edge through the last zeroing cycle; arbiter then returns to IDLE.
  - clr_req held high does not restart the sweep; a new rising edge during a sweep is ignored.
  - Any write pending at sweep start is discarded (no ack).
- Writes:
  - wr_strobe loads a one-deep pending register {row, val}.
  - Commit occurs on the first cycle the arbiter is IDLE with no sweep starting. Commit takes 1 cycle; wr_ack pulses the cycle after the commit (min latency strobe->ack = 2 cycles).
  - A strobe in the same cycle as a commit loads the new entry; the committed one is unaffected.
  - A strobe while an uncommitted entry is pending replaces it (latest wins) and pulses wr_overrun.
  - Strobes during a sweep are held and committed after the sweep.
  - Strobe on the clr_req rising-edge cycle: the sweep starts and the new strobe is held (it is newer than the clear).
- Scanner FSM, states BLANK -> FETCH -> SHOW -> BLANK:
  - BLANK: row_sel=0; counts BLANK cycles.
  - FETCH: requests a read of the current row. It is granted only when no sweep and no pending commit exist that cycle; otherwise it stays in FETCH (row_sel stays 0). On grant, cols latches the store row the next cycle, and the state enters SHOW.
  - SHOW: row_sel = one-hot(current row), cols held constant for DWELL cycles. Then row = (row+1) mod ROWS and return to BLANK.
  - frame_tick pulses on the final SHOW cycle of row ROWS-1.
- Coherence: the lit row shows the value at its fetch. A write to the currently lit row appears at that row's next fetch. A sweep does not blank the lit row mid-dwell.
- Counters are sized ceil(log2(max(DWELL,BLANK)))+1 bits and wrap only via explicit reload.
- Reset mid-operation aborts the sweep, pending write and scan immediately, with outputs at reset values.

Test Plan:
- Reset, then wr_strobe row=3 val=8'hE0 while idle -> wr_ack 2 cycles later; row 3 lit with cols=8'hE0 during its SHOW window; other rows cols=0.
- clr_req 0->1 after rows 0..7 are written 8'hFF -> clr_busy high 8 cycles; next full frame shows cols=0 on all rows; frame_tick once per 8*(DWELL+BLANK+1) cycles with no contention.
- Two wr_strobe pulses on consecutive cycles during a sweep (row 1 8'h18, then row 1 8'h3C) -> wr_overrun one pulse; a single wr_ack after the sweep; row 1 shows 8'h3C.
- wr_strobe with clr_req rising edge in the same cycle (row 0 8'h07) -> sweep runs, then the write commits; row 0 shows 8'h07.
- FETCH cycle coinciding with a pending commit -> scanner stalls 1 cycle; row_sel=0 in the stall; fetched cols reflect the just-committed value.
- reset_n asserted at sweep cycle 4 with a write pending -> all outputs 0 immediately; after release the store is all-zero, with no wr_ack and no clr_busy.
